// File: rtl/instruction_compressor_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_compressor_if
// Description : Stream and dictionary bus for the instruction compressor.
//               Carries the uncompressed input stream (valid/ready plus
//               branch-target flag), the compressed output stream
//               (valid/ready) and the dictionary write port.
//               master : loader / testbench side (drives inputs, out_ready)
//               slave  : compressor side (drives in_ready, out_valid, out_word)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_compressor_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 4
);
  // input instruction stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr;
  logic             in_break;

  // compressed output stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;

  // dictionary write port
  logic             dict_we;
  logic [IDXW-1:0]  dict_idx;
  logic [WIDTH-1:0] dict_first;
  logic [WIDTH-1:0] dict_second;

  modport master (
    output in_valid, in_instr, in_break, out_ready,
    output dict_we, dict_idx, dict_first, dict_second,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_instr, in_break, out_ready,
    input  dict_we, dict_idx, dict_first, dict_second,
    output in_ready, out_valid, out_word
  );
endinterface
`default_nettype wire

// File: rtl/instruction_compressor.sv
`default_nettype none
// ============================================================================
// Module      : instruction_compressor
// Description : Streaming pair compressor. Each adjacent pair of instructions
//               that matches a dictionary entry is replaced by one token word
//               {OPCODE, byte address of the entry in the token table}; all
//               other instructions pass through raw. One instruction is held
//               back so it can be paired with the next one.
// Ports       : clk        - clock
//               reset      - asynchronous reset, active low
//               bus        - slave side of instruction_compressor_if
//                            (input stream, output stream, dictionary write)
//               flush      - level request: emit the held instruction
//               idle       - nothing held and no pending output
//               err        - sticky: a raw word carried OPCODE in its top bits
//               tok_count  - tokens loaded into the output register (wraps)
//               raw_count  - raw words loaded into the output register (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_compressor #(
  parameter int                      WIDTH         = 32,
  parameter int                      ENCODE_LENGTH = 4,
  parameter logic [ENCODE_LENGTH-1:0] OPCODE       = 4'b1111,
  parameter int                      DEPTH         = 16,
  parameter int                      IDXW          = 4
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  instruction_compressor_if.slave        bus,
  input  wire logic                      flush,
  output logic                           idle,
  output logic                           err,
  output logic [WIDTH-1:0]               tok_count,
  output logic [WIDTH-1:0]               raw_count
);

  localparam int c_addr_w = WIDTH - ENCODE_LENGTH;

  localparam logic [0:0] c_st_empty = 1'b0;
  localparam logic [0:0] c_st_hold  = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_word;
  logic             r_err;
  logic [WIDTH-1:0] r_tok_count;
  logic [WIDTH-1:0] r_raw_count;

  logic [DEPTH-1:0] r_dict_valid;
  logic [WIDTH-1:0] r_dict_first  [DEPTH];
  logic [WIDTH-1:0] r_dict_second [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_slot_free;
  logic w_in_ready;
  logic w_accept;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_in_ready  = w_slot_free && !flush;
  assign w_accept    = bus.in_valid && w_in_ready;

  // --------------------------------------------------------------------------
  // Dictionary lookup against the registered contents, so a write landing in
  // the same cycle only takes effect for later pairs. Scanning from the top
  // down lets the lowest matching index overwrite the result last.
  // --------------------------------------------------------------------------
  logic            w_hit;
  logic [IDXW-1:0] w_hit_idx;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_dict_valid[k] &&
          (r_dict_first[k] == r_hold) &&
          (r_dict_second[k] == bus.in_instr)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDXW'(k);
      end
    end
    // a branch target may never be folded into the preceding instruction
    if (bus.in_break) begin
      w_hit = 1'b0;
    end
  end

  // entry k lives at token-table words 2k/2k+1, i.e. byte address 8k
  logic [c_addr_w-1:0] w_tok_addr;
  logic [WIDTH-1:0]    w_token;

  assign w_tok_addr = c_addr_w'({w_hit_idx, 3'b000});
  assign w_token    = {OPCODE, w_tok_addr};

  // --------------------------------------------------------------------------
  // Output-load decisions
  // --------------------------------------------------------------------------
  logic w_load_tok;
  logic w_load_raw;
  logic w_raw_is_marker;

  always_comb begin
    w_load_tok = 1'b0;
    w_load_raw = 1'b0;
    if (r_state == c_st_hold) begin
      if (w_accept) begin
        w_load_tok = w_hit;
        w_load_raw = !w_hit;
      end else if (flush && w_slot_free) begin
        w_load_raw = 1'b1;
      end
    end
  end

  // a raw word that looks like a token would be misdecoded downstream
  assign w_raw_is_marker = (r_hold[WIDTH-1 -: ENCODE_LENGTH] == OPCODE);

  // --------------------------------------------------------------------------
  // Control, hold register, output slot and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_st_empty;
      r_hold       <= '0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_err        <= 1'b0;
      r_tok_count  <= '0;
      r_raw_count  <= '0;
      r_dict_valid <= '0;
    end else begin
      if (bus.dict_we) begin
        r_dict_valid[bus.dict_idx] <= 1'b1;
      end

      // current word leaves when the slot is free; a load below overrides
      if (w_slot_free) begin
        r_out_valid <= 1'b0;
      end

      if (w_load_tok) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_token;
        r_tok_count <= r_tok_count + WIDTH'(1);
      end

      if (w_load_raw) begin
        r_out_valid <= 1'b1;
        r_out_word  <= r_hold;
        r_raw_count <= r_raw_count + WIDTH'(1);
        if (w_raw_is_marker) begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        c_st_empty: begin
          if (w_accept) begin
            r_hold  <= bus.in_instr;
            r_state <= c_st_hold;
          end
        end
        c_st_hold: begin
          if (w_accept) begin
            if (w_hit) begin
              r_state <= c_st_empty;
            end else begin
              r_hold <= bus.in_instr;
            end
          end else if (flush && w_slot_free) begin
            r_state <= c_st_empty;
          end
        end
        default: r_state <= c_st_empty;
      endcase
    end
  end

  // dictionary data needs no reset: entries are gated by r_dict_valid
  always_ff @(posedge clk) begin
    if (bus.dict_we) begin
      r_dict_first[bus.dict_idx]  <= bus.dict_first;
      r_dict_second[bus.dict_idx] <= bus.dict_second;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_out_word;
  assign idle          = (r_state == c_st_empty) && !r_out_valid;
  assign err           = r_err;
  assign tok_count     = r_tok_count;
  assign raw_count     = r_raw_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_compressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_compressor
// Description : Scoreboard bench for instruction_compressor. Stimulus pushes
//               the expected output words; a monitor pops and compares on
//               every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_compressor;
  localparam int WIDTH = 32;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             idle;
  logic             err;
  logic [WIDTH-1:0] tok_count;
  logic [WIDTH-1:0] raw_count;

  instruction_compressor_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  instruction_compressor #(
    .WIDTH(WIDTH), .ENCODE_LENGTH(4), .OPCODE(4'b1111), .DEPTH(16), .IDXW(IDXW)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .idle      (idle),
    .err       (err),
    .tok_count (tok_count),
    .raw_count (raw_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: a word is consumed at the posedge following this negedge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected none", bus.out_word);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("out_word", bus.out_word, e);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] w, input logic brk);
    logic ok;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    bus.in_break = brk;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected accept of %h", w);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_break = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic dict_write(input logic [IDXW-1:0] idx,
                            input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] s);
    bus.dict_we     = 1'b1;
    bus.dict_idx    = idx;
    bus.dict_first  = f;
    bus.dict_second = s;
    @(posedge clk);
    #1;
    bus.dict_we = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_break    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.dict_we     = 1'b0;
    bus.dict_idx    = '0;
    bus.dict_first  = '0;
    bus.dict_second = '0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word", bus.out_word, 32'h0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tok_count", tok_count, 32'd0);
    check("rst_raw_count", raw_count, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ---- two dictionary pairs -> two tokens
    dict_write(4'd0, 32'h00A00093, 32'h00100113);
    dict_write(4'd3, 32'h00000013, 32'h00008067);
    exp_q.push_back(32'hF0000000);
    exp_q.push_back(32'hF0000018);
    send(32'h00A00093, 1'b0);
    send(32'h00100113, 1'b0);
    send(32'h00000013, 1'b0);
    send(32'h00008067, 1'b0);
    do_flush();
    check("tok_count_pairs", tok_count, 32'd2);
    check("raw_count_pairs", raw_count, 32'd0);
    check("idle_after_tokens", 32'(idle), 32'd1);

    // ---- no hit: raw A one cycle after B, raw B after flush
    exp_q.push_back(32'h00000093);
    exp_q.push_back(32'h00000113);
    send(32'h00000093, 1'b0);
    send(32'h00000113, 1'b0);
    check("raw_latency_valid", 32'(bus.out_valid), 32'd1);
    check("raw_latency_word", bus.out_word, 32'h00000093);
    do_flush();
    check("flush_word", bus.out_word, 32'h00000113);
    settle();
    check("idle_after_raw", 32'(idle), 32'd1);

    // ---- break on second word suppresses the pair
    dict_write(4'd5, 32'h00500513, 32'h00600593);
    exp_q.push_back(32'h00500513);
    exp_q.push_back(32'h00600593);
    send(32'h00500513, 1'b0);
    send(32'h00600593, 1'b1);
    do_flush();
    settle();
    check("tok_count_break", tok_count, 32'd2);
    check("raw_count_break", raw_count, 32'd4);

    // ---- backpressure: output held stable, input stalled
    bus.out_ready = 1'b0;
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_word", bus.out_word, 32'h11111111);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    do_flush();
    settle();
    check("raw_count_bp", raw_count, 32'd6);
    check("idle_after_bp", 32'(idle), 32'd1);

    // ---- raw word carrying the token marker sets sticky err
    check("err_before", 32'(err), 32'd0);
    exp_q.push_back(32'hF1234567);
    send(32'hF1234567, 1'b0);
    do_flush();
    settle();
    check("err_set", 32'(err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(err), 32'd1);

    // ---- dictionary write in the same cycle as the pair's second word
    exp_q.push_back(32'h00200093);
    exp_q.push_back(32'h00300113);
    exp_q.push_back(32'hF0000010);
    send(32'h00200093, 1'b0);
    bus.dict_we     = 1'b1;
    bus.dict_idx    = 4'd2;
    bus.dict_first  = 32'h00200093;
    bus.dict_second = 32'h00300113;
    send(32'h00300113, 1'b0);
    bus.dict_we = 1'b0;
    send(32'h00200093, 1'b0);
    send(32'h00300113, 1'b0);
    do_flush();
    settle();
    check("tok_count_samecyc", tok_count, 32'd3);
    check("raw_count_samecyc", raw_count, 32'd9);

    // ---- asynchronous reset mid-stream with a pending output
    send(32'h33333333, 1'b0);
    bus.out_ready = 1'b0;
    send(32'h44444444, 1'b0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_tok", tok_count, 32'd0);
    check("mid_rst_raw", raw_count, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // dictionary valid bits were cleared: former pair now passes raw
    exp_q.push_back(32'h00A00093);
    exp_q.push_back(32'h00100113);
    send(32'h00A00093, 1'b0);
    send(32'h00100113, 1'b0);
    do_flush();
    settle();
    check("post_rst_tok", tok_count, 32'd0);
    check("post_rst_raw", raw_count, 32'd2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
